imem_fetch_unit: RTL
====================

// Module: imem_fetch_unit
// PURPOSE
//  Parametrised instruction-memory + fetch stage for the CPU inside SoC. Holds the
//  program in an internal word array, written through a load port while idle, so
//  benches stop poking program_memory hierarchically. Issues one instruction per
//  cycle to decode over a valid/ready handshake. Supports PC redirect, EBREAK halt
//  and alignment/range faults.
// PARAMETERS
//  XLEN        32     PC / address width in bits
//  ILEN        32     instruction word width in bits
//  IMEM_DEPTH  64     number of instruction words (power of two, >=2)
//  RESET_PC    0      byte address loaded into pc on start (multiple of 4)
// PORTS
//  clk            in   1                   rising-edge clock
//  reset          in   1                   synchronous, active-high
//  load_en        in   1                   write load_data to word load_addr (IDLE only)
//  load_addr      in   $clog2(IMEM_DEPTH)  word index for load
//  load_data      in   ILEN                instruction word to store
//  start          in   1                   IDLE->FETCH, pc<=RESET_PC
//  instr_valid    out  1                   instr/instr_pc hold a fetched instruction
//  instr_ready    in   1                   decode accepts instruction this cycle
//  instr          out  ILEN                fetched instruction word
//  instr_pc       out  XLEN                byte address of instr
//  redirect_valid in   1                   branch/jump: flush and refetch
//  redirect_pc    in   XLEN                byte target of redirect
//  halted         out  1                   EBREAK issued, fetch stopped
//  fault          out  1                   misaligned or out-of-range pc
//  fault_pc       out  XLEN                offending pc, valid while fault=1
// BEHAVIOUR
//  - Reset: state=IDLE; pc=RESET_PC; instr_valid=0; instr=0; instr_pc=0; halted=0;
//    fault=0; fault_pc=0. Memory contents are NOT cleared by reset (reload not needed).
//  - States: IDLE, FETCH, HALT, FAULT. halted=1 iff HALT; fault=1 iff FAULT.
//  - IDLE: load_en writes imem[load_addr]<=load_data at the edge. start -> FETCH.
//    load_en and start in same cycle: write and start both take effect; first fetch
//    (next cycle) sees the new word. load_en outside IDLE is ignored.
//  - FETCH, per edge, priority order:
//    1 redirect_valid: instr_valid<=0 (pending word dropped even if ready=1),
//      pc<=redirect_pc, no issue this cycle.
//    2 slot free (!instr_valid || instr_ready): check pc. pc[1:0]!=0 or
//      pc[XLEN-1:2]>=IMEM_DEPTH -> FAULT, fault_pc<=pc, instr_valid<=0.
//      Else issue: instr<=imem[pc>>2], instr_pc<=pc, instr_valid<=1, pc<=pc+4.
//      If issued word == 32'h0010_0073 (EBREAK) -> HALT after issuing it.
//    3 slot busy (instr_valid && !instr_ready): hold instr, instr_pc, pc unchanged.
//  - Latency: first instr_valid one cycle after start is sampled; with instr_ready
//    held 1, one instruction per cycle, instr_pc stepping by 4.
//  - pc+4 wraps modulo 2^XLEN; reaching IMEM_DEPTH*4 faults on the next issue attempt,
//    never wraps into word 0.
//  - HALT/FAULT: no further issue; a pending instr_valid stays until accepted, then
//    clears. redirect_valid and start ignored. Only reset leaves HALT/FAULT.
//  - instr/instr_pc stable while instr_valid && !instr_ready (AXI-style hold).
//  - Reset mid-operation: all outputs return to reset values next edge; imem retained.
// TESTING
//  1 Load {imm=3,rs1=0,addi,rd=5}@0, {imm=4,rs1=5,addi,rd=5}@1, start, ready=1 ->
//    cycle+1 valid instr=0x00300293 pc=0; cycle+2 instr=0x00428293 pc=4.
//  2 Backpressure: ready=0 for 3 cycles after first valid -> instr=0x00300293,
//    pc=0 held; ready=1 -> pc=4 word next cycle, no word skipped or duplicated.
//  3 Redirect to 0x10 while word at pc=4 pending -> valid drops 1 cycle, then
//    instr_pc=0x10 with imem[4]; redirect to 0x12 -> fault=1, fault_pc=0x12.
//  4 Run past end (IMEM_DEPTH=4, no EBREAK) -> pcs 0,4,8,12 issued, then fault=1,
//    fault_pc=0x10, valid=0 after last accept.
//  5 EBREAK at word 2 -> issued with instr_pc=8, halted=1, no pc=12 fetch; start ignored.
//  6 Reset asserted mid-FETCH, then start without reloading -> same program replays from pc=0.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction memory with single-slot fetch stage and valid/ready issue
module imem_fetch_unit #(
    parameter int unsigned      XLEN       = 32,
    parameter int unsigned      ILEN       = 32,
    parameter int unsigned      IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [ILEN-1:0]               load_data,
    input  logic                          start,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [ILEN-1:0]               instr,
    output logic [XLEN-1:0]               instr_pc,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          halted,
    output logic                          fault,
    output logic [XLEN-1:0]               fault_pc
);

    localparam int unsigned     AW     = $clog2(IMEM_DEPTH);
    localparam logic [ILEN-1:0] EBREAK = ILEN'(32'h0010_0073);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT,
        S_FAULT
    } state_t;

    // Program storage; deliberately outside the reset domain so a reset
    // mid-run lets the same program be replayed without reloading.
    logic [ILEN-1:0] imem [IMEM_DEPTH];

    state_t          state;
    state_t          state_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic            instr_valid_n;
    logic [ILEN-1:0] instr_n;
    logic [XLEN-1:0] instr_pc_n;
    logic [XLEN-1:0] fault_pc_n;

    logic            slot_free;
    logic            pc_misaligned;
    logic            pc_out_of_range;
    logic [ILEN-1:0] rd_word;

    // The output slot can take a new word when empty or being drained this cycle.
    assign slot_free       = !instr_valid || instr_ready;
    assign pc_misaligned   = |pc[1:0];
    // Depth is a power of two, so any set bit above the word index is out of range;
    // this also stops pc+4 from silently wrapping back into word 0.
    assign pc_out_of_range = |pc[XLEN-1:AW+2];
    assign rd_word         = imem[pc[AW+1:2]];

    assign halted = (state == S_HALT);
    assign fault  = (state == S_FAULT);

    // Program load port, only honoured while idle.
    always_ff @(posedge clk) begin
        if (!reset && load_en && (state == S_IDLE)) begin
            imem[load_addr] <= load_data;
        end
    end

    // State and fetch-slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fault_pc    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_valid <= instr_valid_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            fault_pc    <= fault_pc_n;
        end
    end

    // Next-state and slot update: redirect beats issue, issue only into a free slot.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_valid_n = instr_valid;
        instr_n       = instr;
        instr_pc_n    = instr_pc;
        fault_pc_n    = fault_pc;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH;
                    pc_n    = RESET_PC;
                end
            end

            S_FETCH: begin
                if (redirect_valid) begin
                    // Wrong-path word is dropped even if decode is taking it now.
                    instr_valid_n = 1'b0;
                    pc_n          = redirect_pc;
                end else if (slot_free) begin
                    if (pc_misaligned || pc_out_of_range) begin
                        state_n       = S_FAULT;
                        fault_pc_n    = pc;
                        instr_valid_n = 1'b0;
                    end else begin
                        instr_n       = rd_word;
                        instr_pc_n    = pc;
                        instr_valid_n = 1'b1;
                        pc_n          = pc + XLEN'(4);
                        if (rd_word == EBREAK) begin
                            state_n = S_HALT;
                        end
                    end
                end
            end

            S_HALT, S_FAULT: begin
                // Terminal: let the last issued word drain, never issue again.
                if (instr_valid && instr_ready) begin
                    instr_valid_n = 1'b0;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
